mpls_flow_hash: RTL and testbench

- Front end of the MPLS load-distribution path. Walks a packet's label stack one entry per cycle and folds the labels into a 4-bit flow hash.
- Presents that hash as the dividend, together with the ECMP path count as the divisor, to the downstream remainder/divider stage.
- Uses a valid/ready handshake on both the label side and the result side, so one result is held per packet until it is taken.

---
 rtl/mpls_flow_hash.sv | 122 ++++++++++++
 tb/tb_mpls_flow_hash.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mpls_flow_hash.sv
// MPLS label-stack flow hash: folds up to MAX_LABELS labels into a 4-bit dividend plus path-count divisor.
// Optional MPLS_FLOW_SEED_EN adds hash_seed, which replaces the zero starting accumulator.
//
// state   | meaning
// IDLE    | no packet in progress, waiting for the first label
// ACCUM   | labels of a packet accepted, BOS not yet seen
// PRESENT | result held on dividend/divisor until hash_rdy
module mpls_flow_hash #(
    parameter int MAX_LABELS = 8,
    parameter int ACC_W      = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        label_vld,
    output logic        label_rdy,
    input  logic [19:0] label_in,
    input  logic        label_bos,
    input  logic [3:0]  path_count,
    input  logic        pkt_abort,
    output logic        hash_vld,
    input  logic        hash_rdy,
    output logic [3:0]  dividend,
    output logic [3:0]  divisor,
    output logic        depth_err
`ifdef MPLS_FLOW_SEED_EN
    ,
    input  logic [ACC_W-1:0] hash_seed
`endif
);

    localparam int CNT_W = $clog2(MAX_LABELS + 2);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LABELS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        PRESENT = 2'd2
    } state_t;

    state_t           state, state_d;
    logic [ACC_W-1:0] acc, acc_d, acc_base, acc_next;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [15:0]      fold;
    logic             accept, below_max, load;

    assign label_rdy = (state != PRESENT) && !reset;
    assign hash_vld  = (state == PRESENT);
    assign accept    = label_vld && label_rdy;
    assign fold      = label_in[15:0] ^ {12'b0, label_in[19:16]};
    assign below_max = (cnt < CNT_MAX);

    // A cleared count marks a fresh packet, so the seed is picked up after reset and every return to IDLE.
`ifdef MPLS_FLOW_SEED_EN
    assign acc_base = (cnt == '0) ? hash_seed : acc;
`else
    assign acc_base = acc;
`endif
    assign acc_next = below_max ? ({acc_base[14:0], acc_base[15]} ^ fold) : acc_base;

    always_comb begin
        state_d   = state;
        acc_d     = acc;
        cnt_d     = cnt;
        load      = 1'b0;
        depth_err = 1'b0;
        case (state)
            IDLE, ACCUM: begin
                if (pkt_abort) begin
                    state_d = IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                end else if (accept) begin
                    acc_d = acc_next;
                    if (below_max) begin
                        cnt_d = cnt + CNT_W'(1);
                    end else if (cnt == CNT_MAX) begin
                        // Count parks one past the limit so only the first ignored label flags.
                        cnt_d     = CNT_MAX + CNT_W'(1);
                        depth_err = 1'b1;
                    end
                    if (label_bos) begin
                        state_d = PRESENT;
                        load    = 1'b1;
                    end else begin
                        state_d = ACCUM;
                    end
                end
            end
            PRESENT: begin
                if (hash_rdy) begin
                    state_d = IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                acc_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            acc      <= '0;
            cnt      <= '0;
            dividend <= 4'h0;
            divisor  <= 4'h0;
        end else begin
            state <= state_d;
            acc   <= acc_d;
            cnt   <= cnt_d;
            if (load) begin
                dividend <= acc_next[15:12] ^ acc_next[11:8] ^ acc_next[7:4] ^ acc_next[3:0];
                divisor  <= path_count;
            end
        end
    end

endmodule

// File: tb/tb_mpls_flow_hash.sv
// Self-checking bench for mpls_flow_hash: packet-level reference model plus directed literal checks.
module tb_mpls_flow_hash;
    localparam int MAX = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        label_vld, label_bos, pkt_abort, hash_rdy;
    logic [19:0] label_in;
    logic [3:0]  path_count;
    logic        label_rdy, hash_vld, depth_err;
    logic [3:0]  dividend, divisor;

    int checks = 0;
    int errors = 0;

    mpls_flow_hash #(.MAX_LABELS(MAX), .ACC_W(16)) dut (
        .clk(clk), .reset(reset),
        .label_vld(label_vld), .label_rdy(label_rdy), .label_in(label_in),
        .label_bos(label_bos), .path_count(path_count), .pkt_abort(pkt_abort),
        .hash_vld(hash_vld), .hash_rdy(hash_rdy), .dividend(dividend),
        .divisor(divisor), .depth_err(depth_err)
`ifdef MPLS_FLOW_SEED_EN
        , .hash_seed(16'h0000)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: the packet's labels so far, and the held result.
    logic [19:0] m_q[$];
    logic        m_present = 1'b0;
    logic [3:0]  m_div, m_dvs;
    int          hs_count = 0;
    int          dep_count = 0;
    logic [3:0]  hs_div, hs_dvs;

    function automatic logic [3:0] model_hash();
        int unsigned a = 0;
        int unsigned f;
        for (int i = 0; i < m_q.size() && i < MAX; i++) begin
            f = (m_q[i] & 20'hFFFF) ^ (m_q[i] >> 16);
            a = (((a << 1) | (a >> 15)) & 32'hFFFF) ^ f;
        end
        return 4'(((a >> 12) ^ (a >> 8) ^ (a >> 4) ^ a) & 32'hF);
    endfunction

    always @(negedge clk) begin
        logic exp_de;
        if (reset) begin
            check("rst_label_rdy", label_rdy, 0);
            check("rst_hash_vld", hash_vld, 0);
            check("rst_dividend", dividend, 0);
            check("rst_divisor", divisor, 0);
            check("rst_depth_err", depth_err, 0);
            m_present = 1'b0;
            m_q.delete();
        end else begin
            check("label_rdy", label_rdy, !m_present);
            check("hash_vld", hash_vld, m_present);
            if (m_present) begin
                check("dividend", dividend, m_div);
                check("divisor", divisor, m_dvs);
            end
            exp_de = !m_present && label_vld && !pkt_abort && (m_q.size() == MAX);
            check("depth_err", depth_err, exp_de);
            if (depth_err) dep_count++;
            if (m_present) begin
                if (hash_rdy) begin
                    hs_div = dividend;
                    hs_dvs = divisor;
                    hs_count++;
                    m_present = 1'b0;
                end
            end else if (pkt_abort) begin
                m_q.delete();
            end else if (label_vld) begin
                m_q.push_back(label_in);
                if (label_bos) begin
                    m_div = model_hash();
                    m_dvs = path_count;
                    m_present = 1'b1;
                    m_q.delete();
                end
            end
        end
    end

    task automatic send_label(input logic [19:0] l, input logic bos, input logic [3:0] pc);
        bit done = 0;
        label_vld = 1'b1; label_in = l; label_bos = bos; path_count = pc;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            done = label_rdy;
            @(posedge clk); #1;
        end
        if (!done) check("label_accept_timeout", 0, 1);
        label_vld = 1'b0;
    endtask

    task automatic wait_hs(input int prev);
        for (int i = 0; i < 30 && hs_count == prev; i++) begin
            @(posedge clk); #1;
        end
        check("handshake_seen", (hs_count != prev), 1);
    endtask

    initial begin
        int prev, dprev;
        reset = 1'b1; label_vld = 0; label_bos = 0; pkt_abort = 0; hash_rdy = 0;
        label_in = '0; path_count = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;

        // single label
        hash_rdy = 1'b1;
        prev = hs_count;
        send_label(20'h12345, 1'b1, 4'h3);
        wait_hs(prev);
        check("single_div", hs_div, 4'h1);
        check("single_dvs", hs_dvs, 4'h3);

        // two labels
        prev = hs_count;
        send_label(20'h00010, 1'b0, 4'h0);
        send_label(20'h00001, 1'b1, 4'h5);
        wait_hs(prev);
        check("two_div", hs_div, 4'h3);
        check("two_dvs", hs_dvs, 4'h5);

        // backpressure
        hash_rdy = 1'b0;
        prev = hs_count;
        send_label(20'h12345, 1'b1, 4'h7);
        repeat (4) begin @(posedge clk); #1; end
        check("bp_no_hs", hs_count, prev);
        hash_rdy = 1'b1;
        wait_hs(prev);
        check("bp_div", hs_div, 4'h1);
        check("bp_dvs", hs_dvs, 4'h7);

        // depth overflow
        prev = hs_count; dprev = dep_count;
        for (int i = 0; i < 10; i++) send_label(20'h00001, (i == 9), 4'h2);
        wait_hs(prev);
        check("depth_pulses", dep_count - dprev, 1);
        check("depth_div", hs_div, 4'h0);

        // abort with simultaneous label
        prev = hs_count;
        send_label(20'h0ABCD, 1'b0, 4'h0);
        send_label(20'h01234, 1'b0, 4'h0);
        pkt_abort = 1'b1;
        send_label(20'h05555, 1'b1, 4'h9);
        pkt_abort = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check("abort_no_hs", hs_count, prev);
        send_label(20'h12345, 1'b1, 4'h4);
        wait_hs(prev);
        check("abort_next_div", hs_div, 4'h1);

        // async reset in PRESENT
        hash_rdy = 1'b0;
        send_label(20'h0FFFF, 1'b1, 4'hA);
        @(posedge clk); #2;
        check("pre_rst_vld", hash_vld, 1);
        reset = 1'b1;
        #1;
        check("async_rst_vld", hash_vld, 0);
        check("async_rst_div", dividend, 0);
        @(posedge clk); #2;
        reset = 1'b0;
        @(posedge clk); #1;
        hash_rdy = 1'b1;
        prev = hs_count;
        send_label(20'h12345, 1'b1, 4'h6);
        wait_hs(prev);
        check("post_rst_div", hs_div, 4'h1);
        check("post_rst_dvs", hs_dvs, 4'h6);

        // random traffic against the model
        for (int n = 0; n < 600; n++) begin
            label_vld  = ($urandom_range(0, 3) != 0);
            label_in   = 20'($urandom);
            label_bos  = ($urandom_range(0, 5) == 0);
            path_count = 4'($urandom);
            pkt_abort  = ($urandom_range(0, 15) == 0);
            hash_rdy   = $urandom_range(0, 1);
            @(posedge clk); #1;
        end
        label_vld = 0; pkt_abort = 0; hash_rdy = 1;
        repeat (3) begin @(posedge clk); #1; end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
